// File: rtl/s298_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : s298_bist_ctrl
// Purpose  : BIST sequencer for the s298 core (LFSR stimulus, MISR compaction)
// Revision : 1.0
// ============================================================================
module s298_bist_ctrl #(
  parameter logic [15:0] NUM_PATTERNS = 16'd255,
  parameter int unsigned INIT_CYCLES  = 2,
  parameter logic [7:0]  LFSR_SEED    = 8'h01,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        start,
  input  logic [5:0]  cut_out,
  output logic        cut_g0,
  output logic        cut_g1,
  output logic        cut_g2,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  if (NUM_PATTERNS == 16'd0) begin : g_chk_num
    $error("s298_bist_ctrl: NUM_PATTERNS must be nonzero");
  end
  if (INIT_CYCLES < 1 || INIT_CYCLES > 15) begin : g_chk_init
    $error("s298_bist_ctrl: INIT_CYCLES must be in 1..15");
  end
  if (LFSR_SEED == 8'h00) begin : g_chk_seed
    $error("s298_bist_ctrl: LFSR_SEED must be nonzero");
  end

  localparam logic [15:0] c_INIT_LAST = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] c_PAT_LAST  = NUM_PATTERNS - 16'd1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  logic [7:0]  r_lfsr;
  logic [15:0] r_misr;
  logic [15:0] r_cnt;
  logic        r_g0, r_g1, r_g2;
  logic        r_busy, r_done, r_pass;

  logic [7:0]  w_lfsr_next;
  logic        w_misr_fb;
  logic [15:0] w_misr_next;

  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_misr_fb   = r_misr[15] ^ r_misr[14] ^ r_misr[12] ^ r_misr[3];
  assign w_misr_next = {r_misr[14:0], w_misr_fb} ^ {10'b0, cut_out};

  // r_lfsr always holds the next vector to drive; it is consumed as it is registered out
  always_ff @(negedge CK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_lfsr  <= LFSR_SEED;
      r_misr  <= 16'h0000;
      r_cnt   <= 16'h0000;
      r_g0    <= 1'b1;
      r_g1    <= 1'b0;
      r_g2    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_INIT;
            r_lfsr  <= LFSR_SEED;
            r_misr  <= 16'h0000;
            r_cnt   <= 16'h0000;
            r_g0    <= 1'b1;
            r_g1    <= 1'b0;
            r_g2    <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end else begin
            r_g0 <= 1'b0;
            r_g1 <= 1'b0;
            r_g2 <= 1'b0;
          end
        end
        S_INIT: begin
          if (r_cnt == c_INIT_LAST) begin
            r_state <= S_RUN;
            r_cnt   <= 16'h0000;
            r_g0    <= r_lfsr[7] & r_lfsr[6];
            r_g1    <= r_lfsr[0];
            r_g2    <= r_lfsr[1];
            r_lfsr  <= w_lfsr_next;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RUN: begin
          // the first RUN cycle sees the response to the INIT drive, not a vector
          if (r_cnt != 16'h0000) begin
            r_misr <= w_misr_next;
          end
          if (r_cnt == c_PAT_LAST) begin
            r_state <= S_FLUSH;
            r_g0    <= 1'b0;
            r_g1    <= 1'b0;
            r_g2    <= 1'b0;
          end else begin
            r_cnt  <= r_cnt + 16'd1;
            r_g0   <= r_lfsr[7] & r_lfsr[6];
            r_g1   <= r_lfsr[0];
            r_g2   <= r_lfsr[1];
            r_lfsr <= w_lfsr_next;
          end
        end
        S_FLUSH: begin
          r_state <= S_DONE;
          r_misr  <= w_misr_next;
          r_pass  <= (w_misr_next == GOLDEN_SIG);
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_g0    <= 1'b0;
          r_g1    <= 1'b0;
          r_g2    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign cut_g0    = r_g0;
  assign cut_g1    = r_g1;
  assign cut_g2    = r_g2;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_misr;

endmodule
`default_nettype wire
